stream_param_validator: RTL and testbench
=========================================

STREAM_PARAM_VALIDATOR -- requirements
Module: stream_param_validator

Interface
REQ-001 Parameter NUM_CH, 4, number of independent stream channels (1..16).
REQ-002 Parameter ALIGN_LOG2, 4, width/height alignment is 2^ALIGN_LOG2 pixels.
REQ-003 Parameter MAX_WIDTH, 4096, maximum accepted width; MAX_HEIGHT, 2304, maximum accepted height.
REQ-004 Parameter MAX_FPS, 120, maximum accepted fps.
REQ-005 Parameter MAX_TILE_COLS, 10, maximum tile columns; MAX_TILE_ROWS, 11, maximum tile rows.
REQ-006 Parameter CNT_W, 16, width of per-channel statistics counters.
REQ-007 Localparam CH_W = max(1, clog2(NUM_CH)).
REQ-008 clk  in  1  clock; all state changes on rising edge.
REQ-009 reset  in  1  reset, asynchronous, active-high.
REQ-010 in_valid/in_ready  in/out  1  request handshake.
REQ-011 in_ch  in  CH_W  target channel; profile in 8; width, height in 16; fps in 8; chroma_format in 2; bit_depth in 4; qp in 6; tiles_enabled in 1; tile_cols, tile_rows in 4.
REQ-012 out_valid/out_ready  out/in  1  result handshake.
REQ-013 out_ch out CH_W; out_pass out 1; out_err_mask out 8; out_first_err out 3 (lowest set mask bit, 0 if pass); out_ch_err out 1 (in_ch >= NUM_CH).
REQ-014 stat_clear  in  1  single-cycle clear of statistics.
REQ-015 stat_sel in CH_W; stat_pass_cnt, stat_fail_cnt out CNT_W; cfg_ok out NUM_CH (per-channel last-result-passed flags).

Function
REQ-016 FSM states IDLE, CHK_A, CHK_B, RESP; in_ready = 1 only in IDLE.
REQ-017 IDLE: in_valid=1 registers all request inputs and moves to CHK_A; otherwise stays.
REQ-018 CHK_A evaluates mask bits 0-3, then CHK_B; CHK_B evaluates bits 4-7, then RESP with out_valid=1.
REQ-019 Latency: accept on edge N, out_valid high after edge N+3; outputs stable while out_valid=1 and out_ready=0.
REQ-020 RESP: out_ready=1 completes transfer, returns to IDLE; next request is accepted no earlier than the following edge.
REQ-021 Bit0: profile not 1 or 2.
REQ-022 Bit1: width or height zero or not a multiple of 2^ALIGN_LOG2.
REQ-023 Bit2: width > MAX_WIDTH or height > MAX_HEIGHT.
REQ-024 Bit3: qp > 51.
REQ-025 Bit4: chroma_format != 1.
REQ-026 Bit5: bit_depth not 8 or 10, or profile==1 with bit_depth != 8.
REQ-027 Bit6: fps == 0 or fps > MAX_FPS.
REQ-028 Bit7: tiles_enabled and (tile_cols==0, tile_rows==0, tile_cols > MAX_TILE_COLS, or tile_rows > MAX_TILE_ROWS); ignored when tiles_enabled=0.
REQ-029 out_pass = 1 iff out_err_mask == 0 and out_ch_err == 0; all checks are still evaluated when out_ch_err=1.
REQ-030 On RESP handshake with out_ch_err=0: cfg_ok[ch] <= out_pass; pass or fail counter of ch increments, saturating at 2^CNT_W-1.
REQ-031 out_ch_err=1: no counter or cfg_ok update.
REQ-032 stat_clear zeroes all counters and cfg_ok next edge; wins over a coincident RESP update; FSM unaffected.
REQ-033 stat_pass_cnt/stat_fail_cnt combinationally reflect channel stat_sel; stat_sel >= NUM_CH reads 0.

Reset
REQ-034 Reset forces IDLE; out_valid=0, out_pass=0, out_err_mask=0, out_first_err=0, out_ch_err=0, out_ch=0, counters=0, cfg_ok=0; in_ready=1 after release.
REQ-035 Reset mid-transaction discards the in-flight request; no result or statistics update is produced.

Verification
REQ-036 ch=1, profile=2, 1920x1088, fps=60, chroma=1, depth=10, qp=30, tiles off -> out_valid 3 cycles after accept, pass=1, mask=0x00, cfg_ok[1]=1, pass_cnt[1]=1.
REQ-037 profile=1, depth=10, qp=52, width=1921 -> mask=0x2A, first_err=1, fail_cnt incremented.
REQ-038 tiles_enabled=1, tile_cols=11, tile_rows=0 -> mask=0x80, first_err=7; same with tiles_enabled=0 -> pass.
REQ-039 out_ready held 0 for 5 cycles -> outputs stable, in_ready=0 throughout; in_ch=NUM_CH -> out_ch_err=1, counters unchanged.
REQ-040 stat_clear coincident with RESP handshake -> counters read 0; 2^CNT_W+1 passes -> pass_cnt saturates; reset asserted in CHK_B -> no out_valid, all outputs at reset values.

Source files
------------

// File: rtl/stream_param_validator.sv
// Validates per-channel stream configuration requests over a valid/ready handshake,
// producing an error mask plus per-channel pass/fail statistics and last-result flags.
module stream_param_validator #(
    parameter int NUM_CH        = 4,
    parameter int ALIGN_LOG2    = 4,
    parameter int MAX_WIDTH     = 4096,
    parameter int MAX_HEIGHT    = 2304,
    parameter int MAX_FPS       = 120,
    parameter int MAX_TILE_COLS = 10,
    parameter int MAX_TILE_ROWS = 11,
    parameter int CNT_W         = 16,
    localparam int CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CH_W-1:0]   in_ch,
    input  logic [7:0]        profile,
    input  logic [15:0]       width,
    input  logic [15:0]       height,
    input  logic [7:0]        fps,
    input  logic [1:0]        chroma_format,
    input  logic [3:0]        bit_depth,
    input  logic [5:0]        qp,
    input  logic              tiles_enabled,
    input  logic [3:0]        tile_cols,
    input  logic [3:0]        tile_rows,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CH_W-1:0]   out_ch,
    output logic              out_pass,
    output logic [7:0]        out_err_mask,
    output logic [2:0]        out_first_err,
    output logic              out_ch_err,
    input  logic              stat_clear,
    input  logic [CH_W-1:0]   stat_sel,
    output logic [CNT_W-1:0]  stat_pass_cnt,
    output logic [CNT_W-1:0]  stat_fail_cnt,
    output logic [NUM_CH-1:0] cfg_ok
);

    localparam logic [15:0] ALIGN_MASK = 16'((1 << ALIGN_LOG2) - 1);
    localparam logic [15:0] MAX_W16    = 16'(MAX_WIDTH);
    localparam logic [15:0] MAX_H16    = 16'(MAX_HEIGHT);
    localparam logic [7:0]  MAX_FPS8   = 8'(MAX_FPS);
    localparam logic [3:0]  MAX_TC4    = 4'(MAX_TILE_COLS);
    localparam logic [3:0]  MAX_TR4    = 4'(MAX_TILE_ROWS);

    typedef enum logic [1:0] {IDLE, CHK_A, CHK_B, RESP} state_t;

    typedef struct packed {
        logic [7:0]  profile;
        logic [15:0] width;
        logic [15:0] height;
        logic [7:0]  fps;
        logic [1:0]  chroma_format;
        logic [3:0]  bit_depth;
        logic [5:0]  qp;
        logic        tiles_enabled;
        logic [3:0]  tile_cols;
        logic [3:0]  tile_rows;
    } req_t;

    state_t           state, state_nxt;
    req_t             req;
    logic [CH_W-1:0]  req_ch;
    logic             req_ch_err;
    logic [7:0]       mask;
    logic [3:0]       chk_a, chk_b;
    logic [2:0]       first_err;
    logic             handshake;
    logic [CNT_W-1:0] pass_cnt [NUM_CH];
    logic [CNT_W-1:0] fail_cnt [NUM_CH];

    assign in_ready  = (state == IDLE);
    assign handshake = out_valid && out_ready;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // NOTE: next-state defaults to the current state first, so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = CHK_A;
            CHK_A:   state_nxt = CHK_B;
            CHK_B:   state_nxt = RESP;
            RESP:    if (handshake) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        chk_a[0] = (req.profile != 8'd1) && (req.profile != 8'd2);
        chk_a[1] = (req.width == 16'd0) || (req.height == 16'd0) ||
                   ((req.width & ALIGN_MASK) != 16'd0) || ((req.height & ALIGN_MASK) != 16'd0);
        chk_a[2] = (req.width > MAX_W16) || (req.height > MAX_H16);
        chk_a[3] = (req.qp > 6'd51);
        chk_b[0] = (req.chroma_format != 2'd1);
        chk_b[1] = ((req.bit_depth != 4'd8) && (req.bit_depth != 4'd10)) ||
                   ((req.profile == 8'd1) && (req.bit_depth != 4'd8));
        chk_b[2] = (req.fps == 8'd0) || (req.fps > MAX_FPS8);
        chk_b[3] = req.tiles_enabled &&
                   ((req.tile_cols == 4'd0) || (req.tile_rows == 4'd0) ||
                    (req.tile_cols > MAX_TC4) || (req.tile_rows > MAX_TR4));
    end

    // Descending scan leaves the lowest set bit as the winner.
    always_comb begin
        first_err = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (mask[i]) first_err = 3'(i);
        end
    end

    // The result bank is loaded on the first RESP cycle, giving a three-edge accept-to-valid latency.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req           <= '0;
            req_ch        <= '0;
            req_ch_err    <= 1'b0;
            mask          <= '0;
            out_valid     <= 1'b0;
            out_ch        <= '0;
            out_pass      <= 1'b0;
            out_err_mask  <= '0;
            out_first_err <= '0;
            out_ch_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    req        <= '{profile, width, height, fps, chroma_format, bit_depth,
                                    qp, tiles_enabled, tile_cols, tile_rows};
                    req_ch     <= in_ch;
                    req_ch_err <= (int'(in_ch) >= NUM_CH);
                    mask       <= '0;
                end
                CHK_A: mask[3:0] <= chk_a;
                CHK_B: mask[7:4] <= chk_b;
                RESP: begin
                    if (!out_valid) begin
                        out_valid     <= 1'b1;
                        out_ch        <= req_ch;
                        out_err_mask  <= mask;
                        out_first_err <= first_err;
                        out_ch_err    <= req_ch_err;
                        out_pass      <= (mask == 8'd0) && !req_ch_err;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: the counter arrays are small flop banks, not RAM, so they take the async reset like any flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset || stat_clear) begin
            for (int i = 0; i < NUM_CH; i++) begin
                pass_cnt[i] <= '0;
                fail_cnt[i] <= '0;
            end
            cfg_ok <= '0;
        end else if (handshake && !out_ch_err) begin
            cfg_ok[out_ch] <= out_pass;
            if (out_pass) begin
                if (pass_cnt[out_ch] != '1) pass_cnt[out_ch] <= pass_cnt[out_ch] + 1'b1;
            end else begin
                if (fail_cnt[out_ch] != '1) fail_cnt[out_ch] <= fail_cnt[out_ch] + 1'b1;
            end
        end
    end

    assign stat_pass_cnt = (int'(stat_sel) < NUM_CH) ? pass_cnt[stat_sel] : '0;
    assign stat_fail_cnt = (int'(stat_sel) < NUM_CH) ? fail_cnt[stat_sel] : '0;

endmodule

// File: tb/tb_stream_param_validator.sv
// Directed bench for stream_param_validator: latency, every mask bit, back-pressure,
// channel-range error, statistics clear/saturation and mid-transaction reset.
module tb_stream_param_validator;

    localparam int NUM_CH = 3;
    localparam int CNT_W  = 4;
    localparam int CH_W   = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [CH_W-1:0]   in_ch = '0;
    logic [7:0]        profile = '0;
    logic [15:0]       width = '0, height = '0;
    logic [7:0]        fps = '0;
    logic [1:0]        chroma_format = '0;
    logic [3:0]        bit_depth = '0;
    logic [5:0]        qp = '0;
    logic              tiles_enabled = 1'b0;
    logic [3:0]        tile_cols = '0, tile_rows = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [CH_W-1:0]   out_ch;
    logic              out_pass;
    logic [7:0]        out_err_mask;
    logic [2:0]        out_first_err;
    logic              out_ch_err;
    logic              stat_clear = 1'b0;
    logic [CH_W-1:0]   stat_sel = '0;
    logic [CNT_W-1:0]  stat_pass_cnt, stat_fail_cnt;
    logic [NUM_CH-1:0] cfg_ok;

    int n_checks = 0;
    int n_errors = 0;

    stream_param_validator #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_ch(in_ch),
        .profile(profile), .width(width), .height(height), .fps(fps),
        .chroma_format(chroma_format), .bit_depth(bit_depth), .qp(qp),
        .tiles_enabled(tiles_enabled), .tile_cols(tile_cols), .tile_rows(tile_rows),
        .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch), .out_pass(out_pass),
        .out_err_mask(out_err_mask), .out_first_err(out_first_err), .out_ch_err(out_ch_err),
        .stat_clear(stat_clear), .stat_sel(stat_sel), .stat_pass_cnt(stat_pass_cnt),
        .stat_fail_cnt(stat_fail_cnt), .cfg_ok(cfg_ok)
    );

    always #5 clk = ~clk;

    task automatic set_req(input logic [CH_W-1:0] ch, input logic [7:0] prof,
                           input logic [15:0] w, input logic [15:0] h, input logic [7:0] f,
                           input logic [1:0] chroma, input logic [3:0] bd, input logic [5:0] q,
                           input logic te, input logic [3:0] tc, input logic [3:0] tr);
        in_ch = ch; profile = prof; width = w; height = h; fps = f; chroma_format = chroma;
        bit_depth = bd; qp = q; tiles_enabled = te; tile_cols = tc; tile_rows = tr;
    endtask

    // Accept the staged request and count edges until out_valid (bounded at 10).
    task automatic send(output int lat);
        int n = 0;
        while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 10) begin @(posedge clk); #1; lat++; end
    endtask

    task automatic handshake(input logic clr);
        out_ready = 1'b1; stat_clear = clr;
        @(posedge clk); #1;
        out_ready = 1'b0; stat_clear = 1'b0;
    endtask

    task automatic check_result(input string name, input int lat, input logic pass,
                                input logic [7:0] m, input logic [2:0] fe);
        n_checks++;
        if (lat !== 3) begin n_errors++; $display("FAIL %s latency: got %0d expected 3", name, lat); end
        n_checks++;
        if (out_valid !== 1'b1) begin n_errors++; $display("FAIL %s out_valid: got %b expected 1", name, out_valid); end
        n_checks++;
        if (out_pass !== pass) begin n_errors++; $display("FAIL %s out_pass: got %b expected %b", name, out_pass, pass); end
        n_checks++;
        if (out_err_mask !== m) begin n_errors++; $display("FAIL %s mask: got %02h expected %02h", name, out_err_mask, m); end
        n_checks++;
        if (out_first_err !== fe) begin n_errors++; $display("FAIL %s first_err: got %0d expected %0d", name, out_first_err, fe); end
    endtask

    task automatic check_stats(input string name, input logic [CH_W-1:0] ch,
                               input logic [CNT_W-1:0] p, input logic [CNT_W-1:0] f);
        stat_sel = ch; #1;
        n_checks++;
        if (stat_pass_cnt !== p) begin n_errors++; $display("FAIL %s pass_cnt[%0d]: got %0d expected %0d", name, ch, stat_pass_cnt, p); end
        n_checks++;
        if (stat_fail_cnt !== f) begin n_errors++; $display("FAIL %s fail_cnt[%0d]: got %0d expected %0d", name, ch, stat_fail_cnt, f); end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #12;
        n_checks++;
        if (out_valid !== 1'b0 || out_err_mask !== 8'h00 || out_pass !== 1'b0 || cfg_ok !== 3'b000) begin
            n_errors++; $display("FAIL reset outputs: got v=%b m=%02h p=%b ok=%b expected 0", out_valid, out_err_mask, out_pass, cfg_ok);
        end
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (in_ready !== 1'b1) begin n_errors++; $display("FAIL reset in_ready: got %b expected 1", in_ready); end
        check_stats("reset", 2'd0, 4'd0, 4'd0);
    endtask

    task automatic test_pass();
        int lat;
        set_req(2'd1, 8'd2, 16'd1920, 16'd1088, 8'd60, 2'd1, 4'd10, 6'd30, 1'b0, 4'd0, 4'd0);
        send(lat);
        check_result("pass", lat, 1'b1, 8'h00, 3'd0);
        n_checks++;
        if (out_ch !== 2'd1 || out_ch_err !== 1'b0) begin
            n_errors++; $display("FAIL pass out_ch/ch_err: got %0d/%b expected 1/0", out_ch, out_ch_err);
        end
        handshake(1'b0);
        n_checks++;
        if (cfg_ok[1] !== 1'b1) begin n_errors++; $display("FAIL pass cfg_ok[1]: got %b expected 1", cfg_ok[1]); end
        check_stats("pass", 2'd1, 4'd1, 4'd0);
    endtask

    task automatic test_multi_err();
        int lat;
        set_req(2'd2, 8'd1, 16'd1921, 16'd1088, 8'd60, 2'd1, 4'd10, 6'd52, 1'b0, 4'd0, 4'd0);
        send(lat);
        check_result("multi_err", lat, 1'b0, 8'h2A, 3'd1);
        handshake(1'b0);
        check_stats("multi_err", 2'd2, 4'd0, 4'd1);
    endtask

    task automatic test_tiles();
        int lat;
        set_req(2'd2, 8'd2, 16'd1920, 16'd1088, 8'd60, 2'd1, 4'd10, 6'd30, 1'b1, 4'd11, 4'd0);
        send(lat);
        check_result("tiles_bad", lat, 1'b0, 8'h80, 3'd7);
        handshake(1'b0);
        tiles_enabled = 1'b0;
        send(lat);
        check_result("tiles_off", lat, 1'b1, 8'h00, 3'd0);
        handshake(1'b0);
        // Every limit exactly at its maximum is still accepted.
        set_req(2'd2, 8'd1, 16'd4096, 16'd2304, 8'd120, 2'd1, 4'd8, 6'd51, 1'b1, 4'd10, 4'd11);
        send(lat);
        check_result("limits", lat, 1'b1, 8'h00, 3'd0);
        handshake(1'b0);
        check_stats("tiles", 2'd2, 4'd2, 4'd2);
        n_checks++;
        if (cfg_ok[2] !== 1'b1) begin n_errors++; $display("FAIL tiles cfg_ok[2]: got %b expected 1", cfg_ok[2]); end
    endtask

    task automatic test_err_bits();
        int lat;
        set_req(2'd0, 8'd0, 16'd1920, 16'd1088, 8'd60, 2'd1, 4'd10, 6'd30, 1'b0, 4'd0, 4'd0);
        send(lat); check_result("bit0", lat, 1'b0, 8'h01, 3'd0); handshake(1'b0);
        profile = 8'd2; height = 16'd0;
        send(lat); check_result("bit1", lat, 1'b0, 8'h02, 3'd1); handshake(1'b0);
        height = 16'd1088; width = 16'd4112;
        send(lat); check_result("bit2", lat, 1'b0, 8'h04, 3'd2); handshake(1'b0);
        width = 16'd1920; chroma_format = 2'd2;
        send(lat); check_result("bit4", lat, 1'b0, 8'h10, 3'd4); handshake(1'b0);
        chroma_format = 2'd1; bit_depth = 4'd12;
        send(lat); check_result("bit5", lat, 1'b0, 8'h20, 3'd5); handshake(1'b0);
        bit_depth = 4'd10; fps = 8'd121;
        send(lat); check_result("bit6", lat, 1'b0, 8'h40, 3'd6); handshake(1'b0);
        check_stats("err_bits", 2'd0, 4'd0, 4'd6);
    endtask

    task automatic test_backpressure_ch_err();
        int lat;
        set_req(2'd3, 8'd2, 16'd1920, 16'd1088, 8'd60, 2'd1, 4'd10, 6'd52, 1'b0, 4'd0, 4'd0);
        send(lat);
        check_result("ch_err", lat, 1'b0, 8'h08, 3'd3);
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_err_mask !== 8'h08 ||
                out_ch_err !== 1'b1 || out_ch !== 2'd3 || out_pass !== 1'b0) begin
                n_errors++;
                $display("FAIL hold cycle %0d: got v=%b rdy=%b m=%02h ce=%b ch=%0d p=%b expected 1 0 08 1 3 0",
                         i, out_valid, in_ready, out_err_mask, out_ch_err, out_ch, out_pass);
            end
            @(posedge clk); #1;
        end
        handshake(1'b0);
        check_stats("ch_err", 2'd0, 4'd0, 4'd6);
        check_stats("ch_err", 2'd1, 4'd1, 4'd0);
        check_stats("ch_err", 2'd2, 4'd2, 4'd2);
        check_stats("ch_err sel3", 2'd3, 4'd0, 4'd0);
        n_checks++;
        if (cfg_ok !== 3'b110) begin n_errors++; $display("FAIL ch_err cfg_ok: got %b expected 110", cfg_ok); end
    endtask

    task automatic test_stat_clear();
        int lat;
        set_req(2'd0, 8'd2, 16'd1920, 16'd1088, 8'd60, 2'd1, 4'd10, 6'd30, 1'b0, 4'd0, 4'd0);
        send(lat);
        check_result("clear", lat, 1'b1, 8'h00, 3'd0);
        handshake(1'b1);
        for (int c = 0; c < NUM_CH; c++) check_stats("clear", CH_W'(c), 4'd0, 4'd0);
        n_checks++;
        if (cfg_ok !== 3'b000) begin n_errors++; $display("FAIL clear cfg_ok: got %b expected 000", cfg_ok); end
        n_checks++;
        if (in_ready !== 1'b1) begin n_errors++; $display("FAIL clear in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_saturation();
        int lat;
        set_req(2'd1, 8'd2, 16'd1920, 16'd1088, 8'd60, 2'd1, 4'd10, 6'd30, 1'b0, 4'd0, 4'd0);
        for (int i = 0; i < (1 << CNT_W) + 1; i++) begin
            send(lat);
            handshake(1'b0);
        end
        check_stats("saturate", 2'd1, 4'd15, 4'd0);
    endtask

    task automatic test_reset_mid();
        set_req(2'd1, 8'd1, 16'd1921, 16'd1088, 8'd60, 2'd1, 4'd10, 6'd52, 1'b0, 4'd0, 4'd0);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || out_pass !== 1'b0 || out_err_mask !== 8'h00 || out_first_err !== 3'd0 ||
            out_ch_err !== 1'b0 || out_ch !== 2'd0 || cfg_ok !== 3'b000 || in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_mid outputs: got v=%b p=%b m=%02h fe=%0d ce=%b ch=%0d ok=%b rdy=%b expected 0 0 00 0 0 0 000 1",
                     out_valid, out_pass, out_err_mask, out_first_err, out_ch_err, out_ch, cfg_ok, in_ready);
        end
        check_stats("reset_mid", 2'd1, 4'd0, 4'd0);
        @(negedge clk); reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                n_errors++; $display("FAIL reset_mid idle %0d: got v=%b rdy=%b expected 0 1", i, out_valid, in_ready);
            end
        end
    endtask

    initial begin
        test_reset();
        test_pass();
        test_multi_err();
        test_tiles();
        test_err_bits();
        test_backpressure_ch_err();
        test_stat_clear();
        test_saturation();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
